// File: rtl/mips_uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a byte-wide UART transmitter.
// A granted word is latched, then sent MSB byte first, one ready/done handshake
// per byte. A per-byte watchdog aborts a word whose transmitter stalls.
module mips_uart_tx_arbiter #(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned NBITS          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           i_req,
  input  logic [NBITS-1:0]     i_word0,
  input  logic [NBITS-1:0]     i_word1,
  output logic [1:0]           o_ack,
  output logic                 o_grant,
  output logic                 o_busy,
  output logic                 o_timeout,
  output logic [DATA_BITS-1:0] o_uart_tx_data,
  output logic                 o_uart_tx_ready,
  input  logic                 i_uart_tx_done
);

  localparam int unsigned NumBytes = NBITS / DATA_BITS;
  localparam int unsigned TmoW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      LastByte = 3'(NumBytes);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait
  } state_e;

  state_e               state_q, state_d;
  logic [NBITS-1:0]     shift_q, shift_d;
  logic [2:0]           byte_cnt_q, byte_cnt_d;
  logic [TmoW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                 last_grant_q, last_grant_d;
  logic [1:0]           ack_q, ack_d;
  logic                 grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic                 ready_q, ready_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  logic                 pick;
  logic [NBITS-1:0]     pick_word;

  // Round-robin choice: the requester that was not served last wins if it asks.
  always_comb begin
    pick      = i_req[~last_grant_q] ? ~last_grant_q : last_grant_q;
    pick_word = pick ? i_word1 : i_word0;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    last_grant_d = last_grant_q;
    ack_d        = 2'b00;
    grant_d      = grant_q;
    busy_d       = busy_q;
    timeout_d    = timeout_q;
    ready_d      = ready_q;
    data_d       = data_q;

    unique case (state_q)
      StIdle: begin
        busy_d  = 1'b0;
        ready_d = 1'b0;
        // No grant while an ack is still on the wire: the requester has not yet
        // had a chance to drop its request.
        if (i_req != 2'b00 && ack_q == 2'b00) begin
          state_d    = StSend;
          shift_d    = pick_word;
          grant_d    = pick;
          busy_d     = 1'b1;
          byte_cnt_d = '0;
          tmo_cnt_d  = '0;
          data_d     = pick_word[NBITS-1 -: DATA_BITS];
          ready_d    = 1'b1;
        end
      end

      StSend, StWait: begin
        if (tmo_cnt_q == TmoLast) begin
          // Stalled transmitter: abort the word, takes precedence over handshakes.
          state_d      = StIdle;
          ready_d      = 1'b0;
          busy_d       = 1'b0;
          timeout_d    = 1'b1;
          ack_d        = grant_q ? 2'b10 : 2'b01;
          last_grant_d = grant_q;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
          if (state_q == StSend) begin
            if (!i_uart_tx_done) begin
              ready_d    = 1'b0;
              byte_cnt_d = byte_cnt_q + 3'd1;
              state_d    = StWait;
            end
          end else if (i_uart_tx_done) begin
            if (byte_cnt_q < LastByte) begin
              shift_d   = shift_q << DATA_BITS;
              data_d    = shift_q[NBITS-DATA_BITS-1 -: DATA_BITS];
              ready_d   = 1'b1;
              tmo_cnt_d = '0;
              state_d   = StSend;
            end else begin
              state_d      = StIdle;
              busy_d       = 1'b0;
              ack_d        = grant_q ? 2'b10 : 2'b01;
              last_grant_d = grant_q;
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any word in flight without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      ack_q        <= 2'b00;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      ready_q      <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      ready_q      <= ready_d;
      data_q       <= data_d;
    end
  end

  assign o_ack           = ack_q;
  assign o_grant         = grant_q;
  assign o_busy          = busy_q;
  assign o_timeout       = timeout_q;
  assign o_uart_tx_data  = data_q;
  assign o_uart_tx_ready = ready_q;

endmodule

// File: tb/tb_mips_uart_tx_arbiter.sv
// Bench for mips_uart_tx_arbiter: directed word table, multi-cycle corner
// sequences (word change, timeout, reset mid-word, contention) and a random
// phase checked against a transaction-level round-robin model.
module tb_mips_uart_tx_arbiter;

  localparam int unsigned DB = 8;
  localparam int unsigned NB = 32;
  localparam int unsigned TC = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    i_req;
  logic [NB-1:0] i_word0, i_word1;
  logic [1:0]    o_ack;
  logic          o_grant, o_busy, o_timeout;
  logic [DB-1:0] o_uart_tx_data;
  logic          o_uart_tx_ready;
  logic          i_uart_tx_done;

  mips_uart_tx_arbiter #(
    .DATA_BITS      (DB),
    .NBITS          (NB),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_req           (i_req),
    .i_word0         (i_word0),
    .i_word1         (i_word1),
    .o_ack           (o_ack),
    .o_grant         (o_grant),
    .o_busy          (o_busy),
    .o_timeout       (o_timeout),
    .o_uart_tx_data  (o_uart_tx_data),
    .o_uart_tx_ready (o_uart_tx_ready),
    .i_uart_tx_done  (i_uart_tx_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // Transmitter model. Mode 0: fixed 2-cycle accept, 10-cycle busy.
  // Mode 1: never accepts (done stuck high). Mode 2: random latencies.
  int         tx_mode;
  int         d1, d2;
  logic [7:0] tx_q[$];

  initial begin : tx_model
    i_uart_tx_done = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_mode != 1 && o_uart_tx_ready === 1'b1 && !reset) begin
        d1 = (tx_mode == 2) ? int'($urandom_range(0, 3)) : 2;
        d2 = (tx_mode == 2) ? int'($urandom_range(1, 6)) : 10;
        repeat (d1) @(negedge clk);
        if (o_uart_tx_ready === 1'b1 && !reset) begin
          tx_q.push_back(o_uart_tx_data);
          i_uart_tx_done = 1'b0;
          repeat (d2) @(negedge clk);
          i_uart_tx_done = 1'b1;
        end
      end
    end
  end

  // Wait (bounded) for o_busy high or o_ack non-zero; expiry counts as a failure.
  task automatic wait_for(input string name, input bit want_ack, input int limit,
                          output int cycles);
    logic hit;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      hit = want_ack ? (o_ack != 2'b00) : (o_busy === 1'b1);
    end while (!hit && cycles < limit);
    check(name, 32'(hit), 32'd1);
  endtask

  // Compare the bytes collected by the transmitter with a word, MSB byte first.
  task automatic check_word(input string name, input logic [31:0] exp);
    logic [31:0] got;
    got = '0;
    check($sformatf("%s_count", name), tx_q.size(), 32'd4);
    for (int i = 0; i < tx_q.size() && i < 4; i++) got = {got[23:0], tx_q[i]};
    check($sformatf("%s_bytes", name), got, exp);
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        exp_grant;
    logic [31:0] exp_word;
  } vec_t;

  localparam int NumVec = 8;
  vec_t vecs[NumVec];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int          cyc;
    int          exp_g;
    int          other;
    int          mdl_last;
    int          active;
    int          acks;
    logic        busy_seen;
    logic [1:0]  pend;
    logic [31:0] pword[2];

    // Expected grants follow round-robin from reset (last served = 1).
    vecs[0] = '{2'b01, 32'h12345678, 32'h00000000, 1'b0, 32'h12345678};
    vecs[1] = '{2'b11, 32'h11111111, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
    vecs[2] = '{2'b11, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 32'hA5A5A5A5};
    vecs[3] = '{2'b01, 32'h00000000, 32'hFFFFFFFF, 1'b0, 32'h00000000};
    vecs[4] = '{2'b10, 32'h33333333, 32'h80000001, 1'b1, 32'h80000001};
    vecs[5] = '{2'b10, 32'h44444444, 32'hFEDCBA98, 1'b1, 32'hFEDCBA98};
    vecs[6] = '{2'b11, 32'h13579BDF, 32'h2468ACE0, 1'b0, 32'h13579BDF};
    vecs[7] = '{2'b11, 32'h9ABCDEF0, 32'h7E7E7E7E, 1'b1, 32'h7E7E7E7E};

    reset   = 1'b1;
    i_req   = 2'b00;
    i_word0 = '0;
    i_word1 = '0;
    tx_mode = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ack", o_ack, 0);
    check("rst_grant", o_grant, 0);
    check("rst_busy", o_busy, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_data", o_uart_tx_data, 0);
    check("rst_ready", o_uart_tx_ready, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", o_busy, 0);
    check("idle_ready", o_uart_tx_ready, 0);

    // Directed word table. The loser of a contention drops its request while
    // the winner is busy and must not be served.
    for (int k = 0; k < NumVec; k++) begin
      tx_q.delete();
      i_word0 = vecs[k].w0;
      i_word1 = vecs[k].w1;
      i_req   = vecs[k].req;
      wait_for($sformatf("vec%0d_wait_grant", k), 1'b0, 20, cyc);
      check($sformatf("vec%0d_grant", k), o_grant, vecs[k].exp_grant);
      check($sformatf("vec%0d_ready", k), o_uart_tx_ready, 1);
      check($sformatf("vec%0d_first_byte", k), o_uart_tx_data, vecs[k].exp_word[31:24]);
      i_req = vecs[k].req & (2'b01 << vecs[k].exp_grant);
      wait_for($sformatf("vec%0d_wait_ack", k), 1'b1, 400, cyc);
      check($sformatf("vec%0d_ack", k), o_ack, 2'b01 << vecs[k].exp_grant);
      check($sformatf("vec%0d_busy_at_ack", k), o_busy, 0);
      check_word($sformatf("vec%0d", k), vecs[k].exp_word);
      i_req = 2'b00;
      @(negedge clk);
      check($sformatf("vec%0d_ack_pulse", k), o_ack, 0);
    end

    // Word changed one cycle after grant must not alter the bytes sent.
    tx_q.delete();
    i_word0 = 32'h12345678;
    i_req   = 2'b01;
    wait_for("chg_wait_grant", 1'b0, 20, cyc);
    check("chg_grant", o_grant, 0);
    i_word0 = 32'hFFFFFFFF;
    wait_for("chg_wait_ack", 1'b1, 400, cyc);
    check("chg_ack", o_ack, 2'b01);
    check_word("chg", 32'h12345678);
    i_req = 2'b00;
    @(negedge clk);

    // Timeout: transmitter never accepts; abort exactly TC cycles after grant.
    tx_mode = 1;
    tx_q.delete();
    i_word1 = 32'h01020304;
    i_req   = 2'b10;
    wait_for("tmo_wait_grant", 1'b0, 20, cyc);
    check("tmo_grant", o_grant, 1);
    check("tmo_flag_before", o_timeout, 0);
    wait_for("tmo_wait_ack", 1'b1, TC + 50, cyc);
    check("tmo_cycles", cyc, TC);
    check("tmo_ack", o_ack, 2'b10);
    check("tmo_flag", o_timeout, 1);
    check("tmo_ready", o_uart_tx_ready, 0);
    check("tmo_busy", o_busy, 0);
    check("tmo_no_bytes", tx_q.size(), 0);
    i_req   = 2'b00;
    tx_mode = 0;
    repeat (5) @(negedge clk);
    check("tmo_sticky", o_timeout, 1);

    // Reset during byte 2: outputs clear at once, no ack.
    tx_q.delete();
    i_word0 = 32'h0BADF00D;
    i_req   = 2'b01;
    wait_for("rmw_wait_grant", 1'b0, 20, cyc);
    cyc = 0;
    while (tx_q.size() < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rmw_byte2_started", 32'(tx_q.size() >= 2), 1);
    #2 reset = 1'b1;
    #1;
    check("rmw_ack", o_ack, 0);
    check("rmw_grant", o_grant, 0);
    check("rmw_busy", o_busy, 0);
    check("rmw_timeout", o_timeout, 0);
    check("rmw_data", o_uart_tx_data, 0);
    check("rmw_ready", o_uart_tx_ready, 0);
    i_req = 2'b00;
    repeat (15) @(negedge clk);
    reset = 1'b0;

    // Contention with both requests held: r0, r1, r0, r1.
    i_word0 = 32'hAAAAAAAA;
    i_word1 = 32'h55555555;
    i_req   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tx_q.delete();
      wait_for($sformatf("rr%0d_wait_grant", k), 1'b0, 20, cyc);
      check($sformatf("rr%0d_ack_idle", k), o_ack, 0);
      check($sformatf("rr%0d_grant", k), o_grant, k % 2);
      wait_for($sformatf("rr%0d_wait_ack", k), 1'b1, 400, cyc);
      check($sformatf("rr%0d_ack", k), o_ack, 2'b01 << (k % 2));
      check_word($sformatf("rr%0d", k), (k % 2 == 1) ? 32'h55555555 : 32'hAAAAAAAA);
      if (k == 3) i_req = 2'b00;
    end

    // Random phase against a transaction-level model.
    tx_mode   = 2;
    tx_q.delete();
    mdl_last  = 1;
    pend      = 2'b00;
    busy_seen = 1'b0;
    active    = 0;
    acks      = 0;
    pword[0]  = '0;
    pword[1]  = '0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (o_busy === 1'b1 && !busy_seen) begin
        // A word started at the last edge; i_req still holds what was sampled.
        check("rand_req_present", 32'(i_req != 2'b00), 1);
        other = 1 - mdl_last;
        exp_g = i_req[other] ? other : mdl_last;
        check("rand_grant", o_grant, exp_g);
        active    = exp_g;
        busy_seen = 1'b1;
      end
      if (o_ack != 2'b00) begin
        check("rand_ack_after_grant", busy_seen, 1);
        check("rand_ack", o_ack, 2'b01 << active);
        check_word("rand", pword[active]);
        tx_q.delete();
        pend[active] = 1'b0;
        mdl_last     = active;
        busy_seen    = 1'b0;
        acks++;
      end
      if (c < 3500) begin
        for (int n = 0; n < 2; n++) begin
          if (!pend[n] && $urandom_range(0, 5) == 0) begin
            pend[n]  = 1'b1;
            pword[n] = $urandom();
          end
        end
      end
      // Only a waiting, not-yet-served requester must present its word.
      i_word0 = (pend[0] && !(busy_seen && active == 0)) ? pword[0] : $urandom();
      i_word1 = (pend[1] && !(busy_seen && active == 1)) ? pword[1] : $urandom();
      i_req   = pend;
    end
    check("rand_drained", {30'd0, pend[1], pend[0] | busy_seen}, 0);
    check("rand_words_served", 32'(acks >= 20), 1);
    check("rand_no_timeout", o_timeout, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
